cipher_word_packer: RTL

//  Downstream stage of stream_cipher: consumes its byte output (dout/dout_valid) and packs

---
 rtl/cipher_word_packer.sv | 111 +++++++++++
 1 files changed

// File: rtl/cipher_word_packer.sv
// Packs a ciphertext byte stream into little-endian words with byte-valid masks and buffers them
// in a first-word-fall-through FIFO with a valid/ready output and a sticky overflow flag.
module cipher_word_packer #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      din,
    input  logic                            din_valid,
    input  logic                            flush,
    output logic [8*WORD_BYTES-1:0]         word_out,
    output logic [WORD_BYTES-1:0]           word_be,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned CW = $clog2(WORD_BYTES);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WW = 8 * WORD_BYTES;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WW-1:0]         acc_q, acc_d, asm_word;
    logic [CW:0]           held;
    logic [WORD_BYTES-1:0] asm_be;
    logic                  push, pop, full, push_ok;
    logic [WW-1:0]         mem_word [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] mem_be   [FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q;

    // Word under assembly, including this edge's byte; held counts bytes after inclusion.
    always_comb begin
        asm_word = acc_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (din_valid && cnt_q == CW'(k)) begin
                asm_word[8*k +: 8] = din;
            end
        end
        held = {1'b0, cnt_q} + {{CW{1'b0}}, din_valid};
        for (int k = 0; k < WORD_BYTES; k++) begin
            asm_be[k] = (k < int'(held));
        end
        push = (din_valid && cnt_q == CW'(WORD_BYTES - 1)) || (flush && held != '0);
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (push) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (din_valid) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = asm_word;
        end
    end

    assign word_valid = (level_q != '0);
    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign pop        = word_valid && word_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push_ok    = push && (!full || pop);

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            level_q <= level_d;
            if (push_ok) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_word[wptr_q] <= asm_word;
            mem_be[wptr_q]   <= asm_be;
        end
    end

    assign word_out   = word_valid ? mem_word[rptr_q] : '0;
    assign word_be    = word_valid ? mem_be[rptr_q] : '0;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule
